nand_flash_ctrl: RTL and testbench
==================================

# nand_flash_ctrl

Command sequencer that sits directly upstream of the 256×8 NAND flash memory array and is its only driver. It accepts host commands (burst read, burst program, full-array erase) over valid/ready handshakes and translates them into cycle-exact `we`/`re`/`erase`/`address`/`data_in` strobes. It captures the array's registered `data_out` and reports completion and error status back to the host.

## Interface
- `ERASE_CYCLES`, default 4: busy-wait cycles after the erase strobe, modelling tBERS. Legal values are ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake. `cmd_ready` = (state==IDLE).
- `cmd_op`  in  2  operation code: 00 READ, 01 PROGRAM, 10 ERASE, 11 illegal.
- `cmd_addr`  in  8  burst start address.
- `cmd_len`  in  4  burst length minus one (1–16 bytes); ignored for ERASE.
- `wr_valid` / `wr_ready` / `wr_data`  in/out/in  1/1/8  program data stream.
- `rd_valid` / `rd_ready` / `rd_data`  out/in/out  1/1/8  read data stream.
- `busy`  out  1  high when state≠IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  status of the last command; valid while `done`=1, held until next accept.
- `mem_we`, `mem_re`, `mem_erase`  out  1  array strobes.
- `mem_addr`  out  8  array address.
- `mem_wdata`  out  8  array write data.
- `mem_rdata`  in  8  array `data_out`, updated at the edge where `re` is sampled.

## Operation
- Accept when `cmd_valid`&`cmd_ready`. On accept:
  - latch `op`, `addr`, and `cnt`=`cmd_len`;
  - clear `err`.
- States: IDLE, PG_ACC, PG_WR, RD_REQ, RD_CAP, RD_OUT, ER_STB, ER_WAIT, ER_VFY, ER_DRN, DONE.
- `mem_*` are decoded from the state and internal registers only; there is no combinational path from `cmd_*`, `wr_*` or `rd_ready`.
- At most one of `mem_we`/`mem_re`/`mem_erase` is high in any cycle. All three are 0 outside PG_WR, RD_REQ, ER_STB and ER_VFY.
- **PROGRAM**
  - PG_ACC: `wr_ready`=1. On handshake, latch `wr_data` and go to PG_WR.
  - PG_WR: `mem_we`=1, `mem_addr`=addr, `mem_wdata`=latched byte.
  - Then: if `cnt`==0 go to DONE; otherwise addr+1, `cnt`−1, back to PG_ACC.
- **READ**
  - RD_REQ: `mem_re`=1, `mem_addr`=addr.
  - RD_CAP: `rd_data`<=`mem_rdata`, `rd_valid`<=1.
  - RD_OUT: hold `rd_data`/`rd_valid` until `rd_ready`. On handshake, `rd_valid`<=0, then go to DONE if `cnt`==0, else addr+1 and back to RD_REQ.
- **ERASE**
  - ER_STB: `mem_erase`=1 for one cycle.
  - ER_WAIT: exactly `ERASE_CYCLES` cycles (down-counter), then go to DONE (or ER_VFY, see Configuration).
- **Illegal op (11):** go straight to DONE with `err`=1. No array access.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Address arithmetic:** 8-bit, modulo 256; a burst starting at 0xFF continues at 0x00.
- **Mid-burst reset:** the FSM is in IDLE on the cycle after the `rst` edge and all strobes are 0. Bytes already programmed stay in the array. No `done` pulse is produced for the aborted command.

## Timing
Cycle 0 is the accept edge.
- **Reset values:** `cmd_ready`=1 and every other output is 0.
- **Read, 1 byte, `rd_ready`=1:**
  - `mem_re` in cycle 1;
  - `rd_valid`=1 in cycle 3;
  - `done` in cycle 4.
  - Each additional byte adds 3 cycles.
- **Program, `wr_valid`=1:** 2 cycles per byte, with `mem_we` in cycles 2, 4, …. For N bytes, `done` is in cycle 2N+1.
- **Erase, no verify:** `mem_erase` in cycle 1, `done` in cycle `ERASE_CYCLES`+2 (6 at the default).
- **Host stalls:** `wr_valid` low or `rd_ready` low stalls in PG_ACC or RD_OUT indefinitely; no strobes are issued while stalled.
- **Command handshake:** `cmd_valid` while busy is ignored and not queued. A new command can be accepted in the cycle after DONE.

## Configuration
- `NAND_CTRL_ERASE_VERIFY_EN`
  - **Defined:**
    - ER_WAIT goes to ER_VFY.
    - ER_VFY issues `mem_re` on addresses 0x00–0xFF, one per cycle, for 256 cycles.
    - Each `mem_rdata` is compared to 0x00 in the following cycle. ER_DRN is one extra cycle that compares the last byte.
    - Any nonzero byte sets `err`=1.
    - `done` is in cycle `ERASE_CYCLES`+259 (263 at the default).
  - **Undefined:** ER_VFY and ER_DRN are absent, and erase `err` is always 0.

## Test plan
- **Reset then program:** reset, program 2 bytes, addr=0x10, data 0xA5, 0x3C, `wr_valid` held high → `mem_we` in cycles 2 and 4 at 0x10/0x11; `done` in cycle 5; `err`=0.
- **Read-back with stall:** read len=1 from 0x10 with `rd_ready` low for 3 cycles → `rd_data`=0xA5 held stable until the handshake; second byte 0x3C; one `done`.
- **Wrap:** program 3 bytes at 0xFF → writes land on 0xFF, 0x00, 0x01; reading 0xFF len=2 returns the same data.
- **Erase:** erase with `ERASE_CYCLES`=4 → `mem_erase` high only in cycle 1; `done` in cycle 6 (macro off) or 263 (macro on, `err`=0). A subsequent read of 0x10 returns 0x00.
- **Illegal op:** `cmd_op`=11 → `done` in cycle 1 with `err`=1; no strobes.
- **Mid-burst reset:** `rst` during the second byte of a 4-byte program → IDLE and strobes 0 on the next cycle; no `done`; first byte remains in the array; a fresh command is accepted.

Source files
------------

// File: rtl/nand_flash_ctrl.sv
// nand_flash_ctrl: command sequencer driving a 256x8 NAND array (burst read/program, full erase).
// Optional post-erase blank check enabled by defining NAND_CTRL_ERASE_VERIFY_EN.
module nand_flash_ctrl #(
    parameter int ERASE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic [7:0] cmd_addr_i,
    input  logic [3:0] cmd_len_i,
    input  logic       wr_valid_i,
    output logic       wr_ready_o,
    input  logic [7:0] wr_data_i,
    output logic       rd_valid_o,
    input  logic       rd_ready_i,
    output logic [7:0] rd_data_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic       mem_we_o,
    output logic       mem_re_o,
    output logic       mem_erase_o,
    output logic [7:0] mem_addr_o,
    output logic [7:0] mem_wdata_o,
    input  logic [7:0] mem_rdata_i
);
    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] PG_ACC  = 4'd1;
    localparam logic [3:0] PG_WR   = 4'd2;
    localparam logic [3:0] RD_REQ  = 4'd3;
    localparam logic [3:0] RD_CAP  = 4'd4;
    localparam logic [3:0] RD_OUT  = 4'd5;
    localparam logic [3:0] ER_STB  = 4'd6;
    localparam logic [3:0] ER_WAIT = 4'd7;
`ifdef NAND_CTRL_ERASE_VERIFY_EN
    localparam logic [3:0] ER_VFY  = 4'd8;
    localparam logic [3:0] ER_DRN  = 4'd9;
`endif
    localparam logic [3:0] DONE    = 4'd10;
    localparam int WW = $clog2(ERASE_CYCLES + 1);

    logic [3:0]    state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          err_q, err_d;
    logic [WW-1:0] wait_q, wait_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        err_d      = err_q;
        wait_d     = wait_q;
        case (state_q)
            IDLE: if (cmd_valid_i) begin
                addr_d  = cmd_addr_i;
                cnt_d   = cmd_len_i;
                err_d   = &cmd_op_i;
                state_d = cmd_op_i == 2'b00 ? RD_REQ :
                          cmd_op_i == 2'b01 ? PG_ACC :
                          cmd_op_i == 2'b10 ? ER_STB : DONE;
            end
            PG_ACC: if (wr_valid_i) begin
                wdata_d = wr_data_i;
                state_d = PG_WR;
            end
            PG_WR: begin
                state_d = cnt_q == 4'd0 ? DONE : PG_ACC;
                addr_d  = cnt_q == 4'd0 ? addr_q : addr_q + 8'd1;
                cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
            end
            RD_REQ: state_d = RD_CAP;
            RD_CAP: begin
                rd_data_d  = mem_rdata_i;
                rd_valid_d = 1'b1;
                state_d    = RD_OUT;
            end
            RD_OUT: if (rd_ready_i) begin
                rd_valid_d = 1'b0;
                state_d    = cnt_q == 4'd0 ? DONE : RD_REQ;
                addr_d     = cnt_q == 4'd0 ? addr_q : addr_q + 8'd1;
                cnt_d      = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
            end
            ER_STB: begin
                wait_d  = WW'(ERASE_CYCLES - 1);
                state_d = ER_WAIT;
            end
            ER_WAIT: begin
                wait_d = wait_q - 1'b1;
`ifdef NAND_CTRL_ERASE_VERIFY_EN
                addr_d  = 8'h00;
                state_d = wait_q == '0 ? ER_VFY : ER_WAIT;
`else
                state_d = wait_q == '0 ? DONE : ER_WAIT;
`endif
            end
`ifdef NAND_CTRL_ERASE_VERIFY_EN
            // read data trails the request by one cycle, so address 0 has nothing to check yet
            ER_VFY: begin
                addr_d  = addr_q + 8'd1;
                err_d   = err_q | (addr_q != 8'h00 && mem_rdata_i != 8'h00);
                state_d = addr_q == 8'hFF ? ER_DRN : ER_VFY;
            end
            ER_DRN: begin
                err_d   = err_q | (mem_rdata_i != 8'h00);
                state_d = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            wait_q     <= wait_d;
        end
    end

    assign cmd_ready_o = state_q == IDLE;
    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE;
    assign err_o       = err_q;
    assign wr_ready_o  = state_q == PG_ACC;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign mem_we_o    = state_q == PG_WR;
    assign mem_erase_o = state_q == ER_STB;
`ifdef NAND_CTRL_ERASE_VERIFY_EN
    assign mem_re_o    = state_q == RD_REQ || state_q == ER_VFY;
`else
    assign mem_re_o    = state_q == RD_REQ;
`endif
    assign mem_addr_o  = (mem_we_o || mem_re_o) ? addr_q : 8'h00;
    assign mem_wdata_o = mem_we_o ? wdata_q : 8'h00;
endmodule

// File: tb/tb_nand_flash_ctrl.sv
// tb_nand_flash_ctrl: directed and randomized checks of nand_flash_ctrl against a shadow array
// and cycle formulas; honours NAND_CTRL_ERASE_VERIFY_EN for erase timing.
module tb_nand_flash_ctrl;
    localparam int EC = 4;
`ifdef NAND_CTRL_ERASE_VERIFY_EN
    localparam int ER_DONE = EC + 259;
    localparam int ER_RES  = 256;
`else
    localparam int ER_DONE = EC + 2;
    localparam int ER_RES  = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_addr = 8'h00;
    logic [3:0] cmd_len = 4'h0;
    logic       wr_valid = 1'b0, wr_ready;
    logic [7:0] wr_data = 8'h00;
    logic       rd_valid, rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic       busy, done, err, mem_we, mem_re, mem_erase;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] ref_mem [256];
    logic [7:0] pdata [16];
    logic [7:0] arr [256];

    always #5 clk = ~clk;

    nand_flash_ctrl #(.ERASE_CYCLES(EC)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
        .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
        .busy_o(busy), .done_o(done), .err_o(err),
        .mem_we_o(mem_we), .mem_re_o(mem_re), .mem_erase_o(mem_erase),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    // array model: registered data_out, erase clears to 0x00
    always @(posedge clk) begin
        if (mem_erase) for (int i = 0; i < 256; i++) arr[i] <= 8'h00;
        else if (mem_we) arr[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= arr[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [1:0] op, input logic [7:0] a, input logic [3:0] len);
        @(negedge clk);
        chk("cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = len;
    endtask

    task automatic prog(input logic [7:0] a, input int n, input bit stall);
        int cyc = 0, beat = 0, wes = 0, done_cyc = -1, last_we = 0;
        accept(2'b01, a, 4'(n - 1));
        wr_valid = 1'b1; wr_data = pdata[0];
        while (done_cyc < 0 && cyc < 400) begin
            @(negedge clk); cyc++; cmd_valid = 1'b0;
            if (cyc == 1) chk("pg_err_clear", 32'(err), 32'd0);
            chk("pg_onehot", 32'($onehot0({mem_we, mem_re, mem_erase})), 32'd1);
            chk("pg_no_re_er", 32'({mem_re, mem_erase}), 32'd0);
            if (mem_we) begin
                chk("pg_addr", 32'(mem_addr), 32'(8'(a + wes)));
                chk("pg_wdata", 32'(mem_wdata), 32'(pdata[4'(wes)]));
                if (!stall) chk("pg_we_cycle", 32'(cyc), 32'(2 * (wes + 1)));
                ref_mem[8'(a + wes)] = pdata[4'(wes)];
                wes++; last_we = cyc;
            end
            if (done) begin done_cyc = cyc; chk("pg_err", 32'(err), 32'd0); end
            if (wr_ready) begin
                wr_valid = stall ? 1'($urandom % 2) : 1'b1;
                wr_data = pdata[4'(beat)];
                if (wr_valid) beat++;
            end
        end
        wr_valid = 1'b0;
        chk("pg_done_seen", 32'(done_cyc >= 0), 32'd1);
        chk("pg_we_count", 32'(wes), 32'(n));
        chk("pg_done_cycle", 32'(done_cyc), 32'(stall ? last_we + 1 : 2 * n + 1));
    endtask

    task automatic rd(input logic [7:0] a, input int n, input bit stall, input int hold);
        int cyc = 0, k = 0, res = 0, done_cyc = -1, last_hs = 0;
        bit timed;
        timed = !stall && hold == 0;
        accept(2'b00, a, 4'(n - 1));
        rd_ready = 1'b0;
        while (done_cyc < 0 && cyc < 400) begin
            @(negedge clk); cyc++; cmd_valid = 1'b0;
            if (cyc == 1) chk("rd_err_clear", 32'(err), 32'd0);
            chk("rd_onehot", 32'($onehot0({mem_we, mem_re, mem_erase})), 32'd1);
            chk("rd_no_we_er", 32'({mem_we, mem_erase}), 32'd0);
            if (mem_re) begin
                chk("rd_addr", 32'(mem_addr), 32'(8'(a + res)));
                if (timed) chk("rd_re_cycle", 32'(cyc), 32'(3 * res + 1));
                res++;
            end
            if (done) begin done_cyc = cyc; chk("rd_err", 32'(err), 32'd0); end
            if (rd_valid) begin
                chk("rd_data", 32'(rd_data), 32'(ref_mem[8'(a + k)]));
                if (timed) chk("rd_valid_cycle", 32'(cyc), 32'(3 * k + 3));
                if (hold > 0) begin rd_ready = 1'b0; hold--; end
                else rd_ready = stall ? 1'($urandom % 2) : 1'b1;
                if (rd_ready) begin k++; last_hs = cyc; end
            end else rd_ready = 1'b0;
        end
        rd_ready = 1'b0;
        chk("rd_done_seen", 32'(done_cyc >= 0), 32'd1);
        chk("rd_bytes", 32'(k), 32'(n));
        chk("rd_re_count", 32'(res), 32'(n));
        chk("rd_done_cycle", 32'(done_cyc), 32'(timed ? 3 * n + 1 : last_hs + 1));
    endtask

    task automatic erase_cmd();
        int cyc = 0, ers = 0, res = 0, done_cyc = -1;
        accept(2'b10, 8'($urandom), 4'($urandom));
        while (done_cyc < 0 && cyc < 600) begin
            @(negedge clk); cyc++;
            cmd_op = 2'b00;
            cmd_valid = cyc < 4;
            chk("er_onehot", 32'($onehot0({mem_we, mem_re, mem_erase})), 32'd1);
            chk("er_no_we", 32'(mem_we), 32'd0);
            if (mem_erase) begin chk("er_cycle", 32'(cyc), 32'd1); ers++; end
            if (mem_re) begin chk("vfy_addr", 32'(mem_addr), 32'(8'(cyc - EC - 2))); res++; end
            if (done) begin done_cyc = cyc; chk("er_err", 32'(err), 32'd0); end
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        chk("er_done_seen", 32'(done_cyc >= 0), 32'd1);
        chk("er_count", 32'(ers), 32'd1);
        chk("er_re_count", 32'(res), 32'(ER_RES));
        chk("er_done_cycle", 32'(done_cyc), 32'(ER_DONE));
    endtask

    initial begin
        logic [7:0] a;
        int n;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_flags", 32'({busy, done, err, rd_valid, wr_ready, mem_we, mem_re, mem_erase}), 32'd0);
        chk("rst_buses", 32'({rd_data, mem_addr, mem_wdata}), 32'd0);
        rst = 1'b0;

        pdata[0] = 8'hA5; pdata[1] = 8'h3C;
        prog(8'h10, 2, 1'b0);
        rd(8'h10, 2, 1'b0, 3);
        pdata[0] = 8'h11; pdata[1] = 8'h22; pdata[2] = 8'h33;
        prog(8'hFF, 3, 1'b0);
        rd(8'hFF, 2, 1'b0, 0);
        rd(8'h01, 1, 1'b0, 0);

        accept(2'b11, 8'h40, 4'h3);
        @(negedge clk); cmd_valid = 1'b0;
        chk("ill_done", 32'(done), 32'd1);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_strobes", 32'({mem_we, mem_re, mem_erase}), 32'd0);
        @(negedge clk);
        chk("ill_done_once", 32'(done), 32'd0);
        chk("ill_err_held", 32'(err), 32'd1);

        erase_cmd();
        rd(8'h10, 1, 1'b0, 0);

        a = 8'($urandom);
        for (int i = 0; i < 4; i++) pdata[i] = 8'($urandom_range(1, 255));
        accept(2'b01, a, 4'd3);
        wr_valid = 1'b1; wr_data = pdata[0];
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        chk("mb_we", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, a, pdata[0]}));
        ref_mem[a] = pdata[0];
        @(negedge clk); wr_data = pdata[1]; rst = 1'b1;
        @(negedge clk); rst = 1'b0; wr_valid = 1'b0;
        chk("mb_idle", 32'({cmd_ready, busy}), 32'b10);
        chk("mb_strobes", 32'({mem_we, mem_re, mem_erase, done}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mb_no_done", 32'({done, mem_we}), 32'd0);
        end
        rd(a, 2, 1'b0, 0);

        for (int it = 0; it < 8; it++) begin
            a = 8'($urandom);
            n = $urandom_range(1, 16);
            for (int i = 0; i < 16; i++) pdata[i] = 8'($urandom);
            prog(a, n, 1'($urandom % 2));
            rd(a, n, 1'($urandom % 2), 0);
            rd(8'($urandom), $urandom_range(1, 4), 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
